// File: rtl/inv_array_pkg.sv
// rtl/inv_array_pkg.sv - shared mode encoding and counter width for the inverter array
package inv_array_pkg;

   typedef enum logic [1:0] {
      PASS   = 2'b00,
      INVERT = 2'b01,
      TOGGLE = 2'b10,
      FORCE0 = 2'b11
   } mode_t;

   localparam int CNT_W = 8;

endpackage

// File: rtl/inv_chan.sv
// rtl/inv_chan.sv - one channel: synchronizer, glitch filter, mode mux, toggle and edge counter
module inv_chan
   import inv_array_pkg::*;
#(
   parameter int FILT_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  mode_t             mode,
   input  logic [FILT_W-1:0] thresh,
   input  logic              tog_clr,
   input  logic              cnt_clr,
   output logic              dout,
   output logic [CNT_W-1:0]  cnt
);

   logic              sync1;
   logic              s;
   logic              filt;
   logic              tog;
   logic [FILT_W-1:0] count;
   logic              fire;
   logic              rise;

   // >= rather than == so a threshold lowered mid-count still fires promptly
   assign fire = (s != filt) && (count >= thresh);
   assign rise = fire && s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
         filt  <= 1'b0;
         count <= '0;
      end else begin
         sync1 <= din;
         s     <= sync1;
         if (s == filt) begin
            count <= '0;
         end else if (fire) begin
            filt  <= s;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   // A config write clears tog even if a rising edge lands on the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tog <= 1'b0;
         cnt <= '0;
      end else begin
         if (tog_clr) begin
            tog <= 1'b0;
         end else if (rise) begin
            tog <= ~tog;
         end
         if (cnt_clr) begin
            cnt <= '0;
         end else if (rise && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= 1'b0;
      end else begin
         case (mode)
            PASS:    dout <= filt;
            INVERT:  dout <= ~filt;
            TOGGLE:  dout <= tog;
            default: dout <= 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/inv_array_ctrl.sv
// rtl/inv_array_ctrl.sv - config decode, per-channel config registers and counter readback mux
module inv_array_ctrl
   import inv_array_pkg::*;
#(
   parameter int         CHANNELS = 4,
   parameter int         FILT_W   = 3,
   parameter logic [1:0] RST_MODE = 2'b01
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] dout,
   input  logic                cfg_we,
   input  logic [2:0]          cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [FILT_W-1:0]   cfg_thresh,
   input  logic [CHANNELS-1:0] cnt_clr,
   input  logic [2:0]          rd_ch,
   output logic [CNT_W-1:0]    rd_cnt
);

   logic [CNT_W-1:0]    cnt [CHANNELS];
   logic [CHANNELS-1:0] wr_hit;
   logic [CNT_W-1:0]    rd_sel;

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_chan
         mode_t             mode_q;
         logic [FILT_W-1:0] thresh_q;

         // Out-of-range channel indices match no slice, so such writes vanish
         assign wr_hit[g] = cfg_we && ({1'b0, cfg_ch} == 4'(g));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               mode_q   <= mode_t'(RST_MODE);
               thresh_q <= '0;
            end else if (wr_hit[g]) begin
               mode_q   <= mode_t'(cfg_mode);
               thresh_q <= cfg_thresh;
            end
         end

         inv_chan #(
            .FILT_W (FILT_W)
         ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .din     (din[g]),
            .mode    (mode_q),
            .thresh  (thresh_q),
            .tog_clr (wr_hit[g]),
            .cnt_clr (cnt_clr[g]),
            .dout    (dout[g]),
            .cnt     (cnt[g])
         );
      end
   endgenerate

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if ({1'b0, rd_ch} == 4'(i)) begin
            rd_sel = cnt[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt <= '0;
      end else begin
         rd_cnt <= rd_sel;
      end
   end

endmodule

// File: doc/inv_array_ctrl.md
INV_ARRAY_CTRL -- requirements
Module: inv_array_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent inverter channels, 1..8.
REQ-002 SHALL have parameter FILT_W, default 3: width of the per-channel glitch-filter threshold.
REQ-003 SHALL have parameter RST_MODE, default 2'b01 (INVERT): per-channel mode loaded at reset.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port din, input, CHANNELS: asynchronous channel inputs.
REQ-007 SHALL have port dout, output, CHANNELS: registered channel outputs.
REQ-008 SHALL have port cfg_we, input, 1: configuration write strobe, one write per asserted cycle.
REQ-009 SHALL have port cfg_ch, input, 3: channel index for the write.
REQ-010 SHALL have port cfg_mode, input, 2: mode to write (00 PASS, 01 INVERT, 10 TOGGLE, 11 FORCE0).
REQ-011 SHALL have port cfg_thresh, input, FILT_W: filter threshold T to write.
REQ-012 SHALL have port cnt_clr, input, CHANNELS: per-channel edge-counter clear, one bit per channel.
REQ-013 SHALL have port rd_ch, input, 3: channel selected for counter readback.
REQ-014 SHALL have port rd_cnt, output, 8: registered edge count of channel rd_ch.

Function
REQ-015 Each channel SHALL pass din through a 2-flop synchronizer to give s.
REQ-016 Filter: count SHALL reset to 0 whenever s == filt; while s != filt it SHALL increment, and on the edge where count == T, filt SHALL take s and count SHALL return to 0.
REQ-017 Consequence: with din changed before edge 1 and held, filt SHALL update at edge 3+T and dout at edge 4+T; pulses shorter than T+1 synchronized cycles SHALL be rejected.
REQ-018 dout SHALL be registered as: PASS = filt, INVERT = ~filt, TOGGLE = tog, FORCE0 = 0.
REQ-019 tog SHALL flip on every edge where filt goes 0->1, in every mode.
REQ-020 The 8-bit edge counter SHALL count filt 0->1 transitions in every mode and SHALL saturate at 255.
REQ-021 A cnt_clr bit asserted together with a counted edge on the same channel SHALL leave the count at 0; clear wins.
REQ-022 On a cfg_we edge with cfg_ch < CHANNELS, the channel's mode and T SHALL load, and its tog SHALL clear to 0; count, filt and the edge counter SHALL be unaffected.
REQ-023 dout SHALL reflect a new mode on the edge following the write edge.
REQ-024 A write with cfg_ch >= CHANNELS SHALL be ignored with no state change.
REQ-025 Lowering T below a filter count already in progress SHALL take effect as count >= T, giving the update on the next edge where s != filt.
REQ-026 rd_cnt SHALL register the count of channel rd_ch one edge later, and SHALL read 0 when rd_ch >= CHANNELS.

Reset
REQ-027 While rst is high, all sync flops, filt, count, tog, edge counters, dout and rd_cnt SHALL be 0, mode SHALL be RST_MODE, and T SHALL be 0.
REQ-028 Reset asserted mid-filter or mid-write SHALL discard the operation; the first post-reset edge SHALL drive dout from filt = 0, so INVERT gives 1.
REQ-029 Reset deassertion SHALL be synchronized externally; the block assumes no rst/clk race.

Structure
REQ-030 Package inv_array_pkg SHALL hold the 2-bit mode enum (PASS, INVERT, TOGGLE, FORCE0) and the constant CNT_W = 8.
REQ-031 Sub-module inv_chan SHALL implement one channel (sync, filter, mode mux, tog, counter) and be instantiated CHANNELS times by a generate loop.
REQ-032 The top SHALL contain only config decode, the per-channel config registers and the rd_cnt mux.

Verification
REQ-033 Reset then idle with din = 0 and default mode SHALL give dout = 4'b1111 after the first edge and rd_cnt = 0.
REQ-034 With PASS and T = 3 on ch0, a 3-cycle din pulse SHALL leave dout[0] unchanged; a 4-cycle pulse SHALL raise dout[0] at edge 7 after the rise.
REQ-035 With TOGGLE on ch1 and three clean rising edges (T = 0), dout[1] SHALL sequence 1, 0, 1, and reading rd_ch = 1 SHALL return 3.
REQ-036 260 rising edges on ch2 SHALL give rd_cnt = 255; cnt_clr[2] coincident with an edge SHALL give rd_cnt = 0.
REQ-037 A write with cfg_ch = 5 at CHANNELS = 4 SHALL change nothing; a FORCE0 write to ch3 SHALL drive dout[3] = 0 on the next edge.
REQ-038 Asserting rst mid-filter with T = 7 SHALL return all outputs to 0 and all modes to INVERT, with no stale filt update after release.
